// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply, multiply-accumulate and divide engine for HI/LO ops.
// Optional feature macro: MULDIV_ACC_EN.
//   - When defined, the ACC state is present and MADD/MADDU/MSUB/MSUBU accumulate into acc_i.
//   - When undefined, opcodes 1xx run as MULT/MULTU and acc_i is ignored.
// Multiply retires MUL_BITS multiplier bits per cycle.
// Divide is restoring, one quotient bit per cycle.
module muldiv_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic                 annul_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 div_by_zero_o
);
   localparam int unsigned RW    = 2 * WIDTH;
   localparam int unsigned N     = WIDTH / MUL_BITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_ACC, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    a_q, a_d;         // multiplicand (shifting left) or dividend/quotient
   logic [WIDTH-1:0] b_q, b_d;         // multiplier (shifting right) or divisor
   logic [RW-1:0]    prod_q, prod_d;   // partial product, or remainder in the low half
   logic             neg_q, neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic [RW-1:0]    result_q, result_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
`ifdef MULDIV_ACC_EN
   logic [RW-1:0]    acc_q, acc_d;
   logic             is_acc_q, is_acc_d;
   logic             is_sub_q, is_sub_d;
`else
   logic             acc_unused;
   assign acc_unused = ^acc_i;
`endif

   logic             signed_op, div_op, sign1, sign2;
   logic [WIDTH-1:0] mag1, mag2;
   logic [RW-1:0]    partial, prod_sum, prod_fin;
   logic [WIDTH:0]   rem_sh;
   logic             q_bit;
   logic [WIDTH-1:0] rem_nx, quo_nx, rem_out, quo_out;

   // Operand decode on start plus one multiply step and one divide step
   always_comb begin
      signed_op = ~op_i[0];
      div_op    = (op_i[2:1] == 2'b01);
      sign1     = signed_op & opdata1_i[WIDTH-1];
      sign2     = signed_op & opdata2_i[WIDTH-1];
      mag1      = sign1 ? -opdata1_i : opdata1_i;
      mag2      = sign2 ? -opdata2_i : opdata2_i;
      partial   = a_q * RW'(b_q[MUL_BITS-1:0]);
      prod_sum  = prod_q + partial;
      prod_fin  = neg_q ? -prod_sum : prod_sum;
      rem_sh    = {prod_q[WIDTH-1:0], a_q[WIDTH-1]};
      q_bit     = (rem_sh >= {1'b0, b_q});
      rem_nx    = q_bit ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
      quo_nx    = {a_q[WIDTH-2:0], q_bit};
      rem_out   = rem_neg_q ? -rem_nx : rem_nx;
      quo_out   = neg_q ? -quo_nx : quo_nx;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      prod_d    = prod_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
`ifdef MULDIV_ACC_EN
      acc_d     = acc_q;
      is_acc_d  = is_acc_q;
      is_sub_d  = is_sub_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cnt_d     = '0;
               a_d       = {{WIDTH{1'b0}}, mag1};
               b_d       = mag2;
               prod_d    = '0;
               neg_d     = sign1 ^ sign2;
               rem_neg_d = sign1;
`ifdef MULDIV_ACC_EN
               acc_d     = acc_i;
               is_acc_d  = op_i[2];
               is_sub_d  = op_i[1];
`endif
               if (!div_op) begin
                  state_d = S_MUL;
               end else if (opdata2_i == '0) begin
                  state_d  = S_DONE;
                  result_d = {opdata1_i, {WIDTH{1'b1}}};
                  dbz_d    = 1'b1;
               end else begin
                  state_d = S_DIV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            prod_d = prod_sum;
            a_d    = a_q << MUL_BITS;
            b_d    = b_q >> MUL_BITS;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
`ifdef MULDIV_ACC_EN
               if (is_acc_q) begin
                  prod_d  = prod_fin;
                  state_d = S_ACC;
               end else begin
                  result_d = prod_fin;
                  dbz_d    = 1'b0;
                  state_d  = S_DONE;
               end
`else
               result_d = prod_fin;
               dbz_d    = 1'b0;
               state_d  = S_DONE;
`endif
            end
         end
`ifdef MULDIV_ACC_EN
         S_ACC: begin
            result_d = is_sub_q ? (acc_q - prod_q) : (acc_q + prod_q);
            dbz_d    = 1'b0;
            state_d  = S_DONE;
         end
`endif
         S_DIV: begin
            prod_d = {{WIDTH{1'b0}}, rem_nx};
            a_d    = {a_q[RW-1:WIDTH], quo_nx};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = {rem_out, quo_out};
               dbz_d    = 1'b0;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Annul drops the operation and leaves the last result untouched
      if (annul_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
         dbz_d    = dbz_q;
      end
      busy_d  = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_ACC);
      ready_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
`ifdef MULDIV_ACC_EN
         acc_q     <= '0;
         is_acc_q  <= 1'b0;
         is_sub_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         prod_q    <= prod_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
`ifdef MULDIV_ACC_EN
         acc_q     <= acc_d;
         is_acc_q  <= is_acc_d;
         is_sub_q  <= is_sub_d;
`endif
      end
   end

   assign busy_o        = busy_q;
   assign ready_o       = ready_q;
   assign result_o      = result_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random stimulus against a transaction-level reference model.
// Honours MULDIV_ACC_EN the same way as the design.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'b000;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic [63:0] acc_i = '0;
   logic        annul_i = 1'b0;
   logic        busy_o, ready_o, div_by_zero_o;
   logic [63:0] result_o;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .acc_i(acc_i),
      .annul_i(annul_i), .busy_o(busy_o), .ready_o(ready_o),
      .result_o(result_o), .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit is_div(input logic [2:0] op);
      return (op == 3'b010) || (op == 3'b011);
   endfunction

   // Cycles from the start edge to the ready cycle
   function automatic int op_latency(input logic [2:0] op, input logic [31:0] b);
      if (is_div(op)) return (b == 32'd0) ? 1 : 33;
`ifdef MULDIV_ACC_EN
      if (op[2]) return 10;
`endif
      return 9;
   endfunction

   // Architectural result computed with plain 64-bit arithmetic
   function automatic logic [63:0] op_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, prod;
      bit          uns;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = 64'(a);
      ub  = 64'(b);
      uns = (op == 3'b001) || (op == 3'b011) || (op == 3'b101) || (op == 3'b111);
      if (is_div(op)) begin
         if (b == 32'd0) return {a, 32'hFFFF_FFFF};
         if (uns) begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
         return {32'(r), 32'(q)};
      end
      if (uns) prod = ua * ub;
      else     prod = 64'(sa * sb);
`ifdef MULDIV_ACC_EN
      if (op == 3'b100 || op == 3'b101) return acc + prod;
      if (op == 3'b110 || op == 3'b111) return acc - prod;
`else
      if (acc === 64'hx) return '0;
`endif
      return prod;
   endfunction

   // Reference model: one operation in flight, counted down in cycles
   logic        m_busy = 1'b0;
   int          m_left = 0;
   logic [63:0] m_res = '0;
   logic        m_dbz = 1'b0;
   logic        exp_busy = 1'b0, exp_ready = 1'b0, exp_dbz = 1'b0;
   logic [63:0] exp_result = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy     <= 1'b0;
         m_left     <= 0;
         exp_busy   <= 1'b0;
         exp_ready  <= 1'b0;
         exp_result <= '0;
         exp_dbz    <= 1'b0;
      end else begin
         exp_ready <= 1'b0;
         if (annul_i) begin
            m_busy   <= 1'b0;
            exp_busy <= 1'b0;
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy     <= 1'b0;
               exp_busy   <= 1'b0;
               exp_ready  <= 1'b1;
               exp_result <= m_res;
               exp_dbz    <= m_dbz;
            end
         end else if (start_i) begin
            if (op_latency(op_i, opdata2_i) == 1) begin
               exp_ready  <= 1'b1;
               exp_result <= op_result(op_i, opdata1_i, opdata2_i, acc_i);
               exp_dbz    <= 1'b1;
            end else begin
               m_busy   <= 1'b1;
               exp_busy <= 1'b1;
               m_left   <= op_latency(op_i, opdata2_i) - 1;
               m_res    <= op_result(op_i, opdata1_i, opdata2_i, acc_i);
               m_dbz    <= 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("busy_o", 64'(busy_o), 64'(exp_busy));
         check("ready_o", 64'(ready_o), 64'(exp_ready));
         check("result_o", result_o, exp_result);
         check("div_by_zero_o", 64'(div_by_zero_o), 64'(exp_dbz));
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc);
      @(negedge clk);
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; acc_i = acc;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Called in cycle 1; returns the cycle index where ready_o is seen, or -1
   task automatic wait_ready(output int lat);
      lat = 1;
      while (!ready_o && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!ready_o) lat = -1;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int          lat;
      bit          seen;
      logic [63:0] prev;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_dbz", 64'(div_by_zero_o), 64'd0);

      // MULT -3 * 5
      issue(3'b000, 32'hFFFF_FFFD, 32'd5, 64'd0);
      check("mult_busy_c1", 64'(busy_o), 64'd1);
      wait_ready(lat);
      check("mult_latency", 64'(lat), 64'd9);
      check("mult_result", result_o, 64'hFFFF_FFFF_FFFF_FFF1);

      // DIV -7 / 2
      issue(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0);
      wait_ready(lat);
      check("div_latency", 64'(lat), 64'd33);
      check("div_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("div_dbz", 64'(div_by_zero_o), 64'd0);

      // DIVU 7 / 0
      issue(3'b011, 32'd7, 32'd0, 64'd0);
      wait_ready(lat);
      check("dbz_latency", 64'(lat), 64'd1);
      check("dbz_flag", 64'(div_by_zero_o), 64'd1);
      check("dbz_result", result_o, {32'h0000_0007, 32'hFFFF_FFFF});

      // MSUB 100 - 3*4
      issue(3'b110, 32'd3, 32'd4, 64'd100);
      wait_ready(lat);
`ifdef MULDIV_ACC_EN
      check("msub_latency", 64'(lat), 64'd10);
      check("msub_result", result_o, 64'h58);
      prev = 64'h58;
`else
      check("msub_latency", 64'(lat), 64'd9);
      check("msub_result", result_o, 64'h0C);
      prev = 64'h0C;
`endif

      // DIVU 100/3 annulled at cycle 10
      issue(3'b011, 32'd100, 32'd3, 64'd0);
      repeat (9) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      check("annul_busy_c11", 64'(busy_o), 64'd0);
      seen = ready_o;
      repeat (40) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      check("annul_result_kept", result_o, prev);

      // Annul and start together: start dropped
      start_i = 1'b1; annul_i = 1'b1; op_i = 3'b000; opdata1_i = 32'd2; opdata2_i = 32'd2;
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      check("annul_start_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      check("annul_start_idle", 64'(busy_o), 64'd0);

      // Back-to-back MULTU issued in the DONE cycle
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
      wait_ready(lat);
      check("b2b_first_latency", 64'(lat), 64'd9);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("b2b_busy", 64'(busy_o), 64'd1);
      wait_ready(lat);
      check("b2b_second_latency", 64'(lat), 64'd9);
      check("b2b_result", result_o, 64'hFFFF_FFFE_0000_0001);

      // Signed divide overflow wraps
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
      wait_ready(lat);
      check("div_ovf_latency", 64'(lat), 64'd33);
      check("div_ovf_result", result_o, {32'h0000_0000, 32'h8000_0000});

      // Random traffic including starts while busy, annuls and zero divisors
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start_i   = ($urandom_range(0, 3) == 0);
         annul_i   = ($urandom_range(0, 60) == 0);
         op_i      = 3'($urandom_range(0, 7));
         opdata1_i = rand_word();
         opdata2_i = rand_word();
         acc_i     = {rand_word(), rand_word()};
      end
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      repeat (40) @(negedge clk);

      // Asynchronous reset in the middle of a divide
      issue(3'b011, 32'd1000, 32'd7, 64'd0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 64'(busy_o), 64'd0);
      check("async_rst_ready", 64'(ready_o), 64'd0);
      check("async_rst_result", result_o, 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_idle", 64'(busy_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide engine serving the EX stage for all HI/LO-producing arithmetic: signed/unsigned multiply, multiply-accumulate/subtract and divide. Operands and the current {HI,LO} are captured on a start strobe; the engine iterates while EX holds the pipeline stalled, then presents a 2×WIDTH result for the HI/LO write path. A single 3-bit opcode selects the operation, and the unit accepts a pipeline annul at any time.

## Interface
- WIDTH, 32: operand width; the result is 2×WIDTH.
- MUL_BITS, 4: multiplier bits retired per cycle; must divide WIDTH evenly.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE or DONE.
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- acc_i  in  2×WIDTH  current {HI,LO}, used by accumulate ops.
- annul_i  in  1  cancel the in-flight operation.
- busy_o  out  1  high in MUL, DIV and ACC states.
- ready_o  out  1  one-cycle pulse: result_o is valid.
- result_o  out  2×WIDTH  multiply result {hi,lo}; divide result {remainder,quotient}.
- div_by_zero_o  out  1  qualifies ready_o: the divisor was zero.

## Operation
- States: IDLE, MUL, DIV, ACC, DONE.
- Start (start_i=1 in IDLE or DONE): capture magnitudes of both operands, both sign bits, op_i, and acc_i.
  - Signed ops (MULT, DIV, MADD, MSUB) take two's-complement magnitudes.
  - Unsigned ops use operands as-is.
- MUL: shift-add, MUL_BITS bits per cycle, for N = WIDTH/MUL_BITS cycles.
  - Afterwards, negate the product if the operand signs differ (signed ops only).
  - Accumulate ops then go to ACC; others go to DONE.
- ACC: one cycle.
  - MADD/MADDU: result = acc + product.
  - MSUB/MSUBU: result = acc − product.
  - All arithmetic is modulo 2^(2×WIDTH).
- DIV: restoring division, 1 quotient bit per cycle, WIDTH cycles.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap, no trap).
- Divisor zero: go directly to DONE.
  - result_o = {opdata1_i, all-ones}.
  - div_by_zero_o = 1.
- DONE: ready_o=1 for exactly one cycle.
  - Next state is IDLE, or a new op state if start_i=1 (back-to-back issue).
- result_o and div_by_zero_o hold until the next ready_o. Intermediate values are never visible on result_o.
- annul_i=1, any state:
  - Next state is IDLE; no ready_o.
  - result_o and div_by_zero_o are unchanged.
  - Annul wins over a simultaneous start_i.
- start_i while busy_o=1 is ignored.

## Timing
- Reset values: state IDLE, busy_o 0, ready_o 0, result_o 0, div_by_zero_o 0.
- Reset mid-operation returns to IDLE immediately (asynchronous).
- Latency, counted from the start edge to the cycle with ready_o high:
  - MULT/MULTU: N+1 cycles (9 at defaults).
  - MADD/MSUB family: N+2 cycles.
  - DIV/DIVU: WIDTH+1 cycles (33).
  - Divide by zero: 1 cycle.
- busy_o rises the cycle after the start edge and falls in the DONE cycle.
- Throughput: one operation per latency period; no bubble needed between back-to-back starts.

## Configuration
- MULDIV_ACC_EN defined: ACC state present; MADD/MADDU/MSUB/MSUBU behave as above.
- MULDIV_ACC_EN undefined:
  - ACC state and the 2×WIDTH adder are removed; acc_i is unused.
  - Opcodes 100/101/110/111 execute as MULT/MULTU/MULT/MULTU, with MULT latency.

## Test plan
- MULT, opdata1=0xFFFFFFFD (−3), opdata2=5, defaults -> ready_o at cycle 9, result_o=0xFFFFFFFF_FFFFFFF1; busy_o high cycles 1–8.
- DIV, opdata1=0xFFFFFFF9 (−7), opdata2=2 -> ready_o at cycle 33, result_o={0xFFFFFFFF, 0xFFFFFFFD}, div_by_zero_o=0.
- DIVU, 7/0 -> ready_o at cycle 1, div_by_zero_o=1, result_o={0x00000007, 0xFFFFFFFF}.
- MSUB with MULDIV_ACC_EN, acc_i=0x00000000_00000064, 3×4 -> ready_o at cycle 10, result_o=0x00000000_00000058. Without the macro, same stimulus -> cycle 9, result_o=0x0000000C.
- DIVU 100/3 started, annul_i pulsed at cycle 10 -> no ready_o, busy_o low from cycle 11, result_o keeps its prior value.
- Annul at cycle 10, then start_i with annul_i both high in the same cycle -> start dropped, stays IDLE. MULTU 0xFFFFFFFF×0xFFFFFFFF issued back-to-back in the DONE cycle -> second ready_o 9 cycles later, result 0xFFFFFFFE_00000001.
